encout_reg_bank: RTL

//   Multi-channel register bank for the encoder-output (ENCOUT) engine: NCH channels, each

---
 rtl/encout_reg_bank.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/encout_reg_bank.sv
// Per-channel register bank for the encoder-output engines.
// Holds control, shadowed posmax, counts, W1C status flags, IRQ and a registered read port.
module encout_reg_bank #(
    parameter int          NCH     = 4,
    parameter int          CW      = 16,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic              i_pclk,
    input  logic              i_preset,
    input  logic [3:0]        i_chsel,
    input  logic [5:0]        i_we,
    input  logic [5:0]        i_re,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_rvalid,
    input  logic [NCH*CW-1:0] i_poscnt_cur,
    input  logic [NCH-1:0]    i_wrap,
    output logic [NCH-1:0]    o_pol,
    output logic [NCH-1:0]    o_ence,
    output logic [NCH*CW-1:0] o_posmax,
    output logic [NCH*CW-1:0] o_pdcnt,
    output logic [NCH*CW-1:0] o_edgecnt,
    output logic [NCH*CW-1:0] o_poscnt_int,
    output logic              o_irq
);

    logic [NCH-1:0] pol_q, pol_d;
    logic [NCH-1:0] irqen_q, irqen_d;
    logic [NCH-1:0] ence_q, ence_d;
    logic [NCH-1:0] wrap_q, wrap_d;
    logic [NCH-1:0] err_q, err_d;
    logic [CW-1:0]  posmax_q [NCH];
    logic [CW-1:0]  posmax_d [NCH];
    logic [CW-1:0]  shadow_q [NCH];
    logic [CW-1:0]  shadow_d [NCH];
    logic [CW-1:0]  pdcnt_q [NCH];
    logic [CW-1:0]  pdcnt_d [NCH];
    logic [CW-1:0]  edgecnt_q [NCH];
    logic [CW-1:0]  edgecnt_d [NCH];
    logic [CW-1:0]  poscnt_q [NCH];
    logic [CW-1:0]  poscnt_d [NCH];
    logic [31:0]    rdata_q, rdata_d;
    logic           rvalid_q, rvalid_d;
    logic           irq_q, irq_d;

    logic [5:0]     we1, re1;
    logic           hit, set_err, clr_wrap, clr_err;
    logic signed [CW-1:0] edg_s;

    // Only the lowest set strobe bit is honoured.
    assign we1 = i_we & (~i_we + 6'd1);
    assign re1 = i_re & (~i_re + 6'd1);

    always_comb begin
        pol_d    = pol_q;
        irqen_d  = irqen_q;
        ence_d   = ence_q;
        wrap_d   = wrap_q;
        err_d    = err_q;
        hit      = 1'b0;
        set_err  = 1'b0;
        clr_wrap = 1'b0;
        clr_err  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            posmax_d[k]  = posmax_q[k];
            shadow_d[k]  = shadow_q[k];
            pdcnt_d[k]   = pdcnt_q[k];
            edgecnt_d[k] = edgecnt_q[k];
            poscnt_d[k]  = poscnt_q[k];
            hit      = (i_chsel == 4'(k));
            set_err  = 1'b0;
            clr_wrap = 1'b0;
            clr_err  = 1'b0;
            if (hit) begin
                if (we1[0]) begin
                    if (ence_q[k]) set_err = 1'b1;
                    else begin
                        pol_d[k]   = i_wdata[0];
                        irqen_d[k] = i_wdata[1];
                    end
                end
                if (we1[1]) begin
                    ence_d[k] = i_wdata[0];
                    clr_wrap  = i_wdata[8];
                    clr_err   = i_wdata[9];
                end
                if (we1[2]) begin
                    if (i_wdata[CW-1:0] == '0) set_err = 1'b1;
                    else begin
                        shadow_d[k] = i_wdata[CW-1:0];
                        if (!ence_q[k]) posmax_d[k] = i_wdata[CW-1:0];
                    end
                end
                if (we1[3]) begin
                    if (i_wdata == 32'd0) set_err = 1'b1;
                    else begin
                        pdcnt_d[k]   = i_wdata[16+:CW];
                        edgecnt_d[k] = i_wdata[0+:CW];
                    end
                end
                if (we1[4]) begin
                    if (ence_q[k]) set_err = 1'b1;
                    else poscnt_d[k] = i_wdata[CW-1:0];
                end
                if (we1[5]) set_err = 1'b1;
            end
            // Reload decision uses the pre-write enable so a same-cycle disable still loads.
            if (i_wrap[k] && ence_q[k]) posmax_d[k] = shadow_q[k];
            wrap_d[k] = i_wrap[k] | (wrap_q[k] & ~clr_wrap);
            err_d[k]  = set_err   | (err_q[k] & ~clr_err);
        end
    end

    always_comb begin
        rdata_d  = 32'd0;
        rvalid_d = |i_re;
        edg_s    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (i_chsel == 4'(k)) begin
                edg_s = edgecnt_q[k];
                if (re1[0]) rdata_d = {30'd0, irqen_q[k], pol_q[k]};
                if (re1[1]) rdata_d = {22'd0, err_q[k], wrap_q[k], 7'd0, ence_q[k]};
                if (re1[2]) rdata_d = 32'(posmax_q[k]);
                if (re1[3]) rdata_d = {16'(pdcnt_q[k]), 16'(edg_s)};
                if (re1[4]) rdata_d = ence_q[k] ? 32'(i_poscnt_cur[k*CW+:CW]) : 32'(poscnt_q[k]);
                if (re1[5]) rdata_d = VERSION;
            end
        end
    end

    assign irq_d = |(irqen_q & (wrap_q | err_q));

    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            pol_q    <= '0;
            irqen_q  <= '0;
            ence_q   <= '0;
            wrap_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                posmax_q[k]  <= '0;
                shadow_q[k]  <= '0;
                pdcnt_q[k]   <= '0;
                edgecnt_q[k] <= '0;
                poscnt_q[k]  <= '0;
            end
        end else begin
            pol_q    <= pol_d;
            irqen_q  <= irqen_d;
            ence_q   <= ence_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
            for (int k = 0; k < NCH; k++) begin
                posmax_q[k]  <= posmax_d[k];
                shadow_q[k]  <= shadow_d[k];
                pdcnt_q[k]   <= pdcnt_d[k];
                edgecnt_q[k] <= edgecnt_d[k];
                poscnt_q[k]  <= poscnt_d[k];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign o_posmax[g*CW+:CW]     = posmax_q[g];
        assign o_pdcnt[g*CW+:CW]      = pdcnt_q[g];
        assign o_edgecnt[g*CW+:CW]    = edgecnt_q[g];
        assign o_poscnt_int[g*CW+:CW] = poscnt_q[g];
    end

    assign o_pol    = pol_q;
    assign o_ence   = ence_q;
    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;
    assign o_irq    = irq_q;

endmodule
